// File: rtl/dbus_pkg.sv
// Shared address map and TCON bit layout for the CPU data-port responder.
package dbus_pkg;

    localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
    localparam logic [31:0] ADDR_TH      = PERIPH_BASE + 32'h00;
    localparam logic [31:0] ADDR_TL      = PERIPH_BASE + 32'h04;
    localparam logic [31:0] ADDR_TCON    = PERIPH_BASE + 32'h08;
    localparam logic [31:0] ADDR_LED     = PERIPH_BASE + 32'h0C;
    localparam logic [31:0] ADDR_DIGI    = PERIPH_BASE + 32'h10;
    localparam logic [31:0] ADDR_SYSTICK = PERIPH_BASE + 32'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;
    localparam int TCON_W  = 3;

endpackage

// File: rtl/dbus_timer.sv
// Memory-mapped reload timer: TH/TL/TCON, tick prescaler and the registered irq.
module dbus_timer
    import dbus_pkg::*;
#(
    parameter int TIMER_PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              th_we_i,
    input  logic              tl_we_i,
    input  logic              tcon_we_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       th_o,
    output logic [31:0]       tl_o,
    output logic [TCON_W-1:0] tcon_o,
    output logic              irq_o
);

    localparam int              PW         = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TIMER_PRESCALE - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic              tick;
    logic              bus_owns;

    assign tick     = tcon_q[TCON_EN] && (presc_q == PRESC_LAST);
    // A bus write to TL or TCON swallows a coincident tick entirely.
    assign bus_owns = tl_we_i || tcon_we_i;

    always_comb begin
        // NOTE: every next-state variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        presc_d = presc_q;
        th_d    = th_q;
        tl_d    = tl_q;
        tcon_d  = tcon_q;

        if (!tcon_q[TCON_EN] || tick) presc_d = '0;
        else                          presc_d = presc_q + 1'b1;

        if (tick && !bus_owns) begin
            if (tl_q != '1) begin
                tl_d = tl_q + 32'd1;
            end else begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) tcon_d[TCON_ST] = 1'b1;
            end
        end

        if (th_we_i)   th_d   = wdata_i;
        if (tl_we_i)   tl_d   = wdata_i;
        if (tcon_we_i) tcon_d = wdata_i[TCON_W-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
        if (reset) begin
            presc_q <= '0;
            th_q    <= '0;
            tl_q    <= '0;
            tcon_q  <= '0;
        end else begin
            presc_q <= presc_d;
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_ST];

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-port responder: data RAM, timer, LED/7-seg registers, combinational read mux.
// Optional free-running systick counter is built only when DBUS_SYSTICK_EN is defined.
module data_bus_responder
    import dbus_pkg::*;
#(
    parameter int RAM_WORDS      = 512,
    parameter int TIMER_PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] MemAddress,
    input  logic [31:0] MemWriteData,
    output logic [31:0] MemReadData,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]       ram_q [RAM_WORDS];
    logic [31:0]       word_addr;
    logic              ram_hit;
    logic [AW-1:0]     ram_idx;
    logic              th_we, tl_we, tcon_we, led_we, digi_we;
    logic [31:0]       th, tl, systick;
    logic [TCON_W-1:0] tcon;
    logic [7:0]        led_q;
    logic [11:0]       digi_q;
    logic [31:0]       rdata;
    logic              unused_byte_lane;

    // Byte-lane bits never select anything; the bus is word-addressed.
    assign unused_byte_lane = ^MemAddress[1:0];
    assign word_addr        = {MemAddress[31:2], 2'b00};
    assign ram_hit          = (MemAddress[31:AW+2] == '0);
    assign ram_idx          = MemAddress[AW+1:2];

    assign th_we   = MemWrite && (word_addr == ADDR_TH);
    assign tl_we   = MemWrite && (word_addr == ADDR_TL);
    assign tcon_we = MemWrite && (word_addr == ADDR_TCON);
    assign led_we  = MemWrite && (word_addr == ADDR_LED);
    assign digi_we = MemWrite && (word_addr == ADDR_DIGI);

    // NOTE: RAM has no reset branch; clearing every word would block mapping it onto block RAM.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) ram_q[ram_idx] <= MemWriteData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            if (led_we)  led_q  <= MemWriteData[7:0];
            if (digi_we) digi_q <= MemWriteData[11:0];
        end
    end

`ifdef DBUS_SYSTICK_EN
    logic [31:0] systick_q;

    always_ff @(posedge clk) begin
        if (reset) systick_q <= '0;
        else       systick_q <= systick_q + 32'd1;
    end

    assign systick = systick_q;
`else
    assign systick = '0;
`endif

    dbus_timer #(
        .TIMER_PRESCALE(TIMER_PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .th_we_i   (th_we),
        .tl_we_i   (tl_we),
        .tcon_we_i (tcon_we),
        .wdata_i   (MemWriteData),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .irq_o     (irq)
    );

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram_q[ram_idx];
        end else begin
            case (word_addr)
                ADDR_TH:      rdata = th;
                ADDR_TL:      rdata = tl;
                ADDR_TCON:    rdata = {{(32-TCON_W){1'b0}}, tcon};
                ADDR_LED:     rdata = {24'b0, led_q};
                ADDR_DIGI:    rdata = {20'b0, digi_q};
                ADDR_SYSTICK: rdata = systick;
                default:      rdata = '0;
            endcase
        end
    end

    assign MemReadData = rdata;
    assign led         = led_q;
    assign digi        = digi_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed scenarios plus randomized bus traffic
// compared against a behavioural model of the register map and timer.
module tb_data_bus_responder;
    import dbus_pkg::*;

    localparam int RAM_WORDS = 512;
    localparam int PRE       = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] MemAddress = '0;
    logic [31:0] MemWriteData = '0;
    logic [31:0] MemReadData;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_ram [int];
    logic [31:0] m_th, m_tl, m_systick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;
    int          m_presc;

    always #10 clk = ~clk;

    data_bus_responder #(
        .RAM_WORDS(RAM_WORDS),
        .TIMER_PRESCALE(PRE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemReadData  (MemReadData),
        .led          (led),
        .digi         (digi),
        .irq          (irq)
    );

    function automatic bit is_ram(input logic [31:0] addr);
        return addr < 32'(RAM_WORDS * 4);
    endfunction

    function automatic bit model_known(input logic [31:0] addr);
        if (is_ram(addr)) return m_ram.exists(int'(addr >> 2));
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (is_ram(a)) return m_ram.exists(int'(a >> 2)) ? m_ram[int'(a >> 2)] : 32'h0;
        case (a)
            ADDR_TH:      return m_th;
            ADDR_TL:      return m_tl;
            ADDR_TCON:    return {29'b0, m_tcon};
            ADDR_LED:     return {24'b0, m_led};
            ADDR_DIGI:    return {20'b0, m_digi};
            ADDR_SYSTICK: begin
`ifdef DBUS_SYSTICK_EN
                return m_systick;
`else
                return 32'h0;
`endif
            end
            default:      return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge with the given bus inputs.
    task automatic model_step(input logic rst, input logic we, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a;
        bit          tick;
        a = {addr[31:2], 2'b00};
        if (we && is_ram(a)) m_ram[int'(a >> 2)] = data;
        if (rst) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_systick = 0; m_presc = 0;
            return;
        end
        tick = m_tcon[0] && (m_presc == PRE - 1);
        m_presc = (!m_tcon[0] || tick) ? 0 : m_presc + 1;
        if (tick && !(we && (a == ADDR_TL || a == ADDR_TCON))) begin
            if (m_tl != 32'hFFFF_FFFF) m_tl = m_tl + 1;
            else begin
                m_tl = m_th;
                if (m_tcon[1]) m_tcon[2] = 1'b1;
            end
        end
        if (we) begin
            if (a == ADDR_TH)   m_th   = data;
            if (a == ADDR_TL)   m_tl   = data;
            if (a == ADDR_TCON) m_tcon = data[2:0];
            if (a == ADDR_LED)  m_led  = data[7:0];
            if (a == ADDR_DIGI) m_digi = data[11:0];
        end
        m_systick = m_systick + 1;
    endtask

    // Entered just after a negedge; applies inputs, clocks one edge, returns after the next negedge.
    task automatic bus_cycle(input logic rst, input logic we, input logic [31:0] addr, input logic [31:0] data);
        reset = rst; MemWrite = we; MemAddress = addr; MemWriteData = data;
        @(posedge clk);
        model_step(rst, we, addr, data);
        @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic peek(input logic [31:0] addr);
        MemWrite = 1'b0; MemAddress = addr;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h0);
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h0);
        total++; if (led !== 8'h00)  begin bad++; $display("FAIL reset_led got=%h exp=00", led); end
        total++; if (digi !== 12'h0) begin bad++; $display("FAIL reset_digi got=%h exp=000", digi); end
        total++; if (irq !== 1'b0)   begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        peek(ADDR_TH);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL reset_th got=%h exp=0", MemReadData); end
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL reset_tl got=%h exp=0", MemReadData); end
        peek(ADDR_TCON);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL reset_tcon got=%h exp=0", MemReadData); end
        peek(ADDR_SYSTICK);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL reset_systick got=%h exp=0", MemReadData); end
    endtask

    task automatic test_ram();
        bus_cycle(1'b0, 1'b1, 32'h10, 32'h1111_1111);
        MemWrite = 1'b1; MemAddress = 32'h10; MemWriteData = 32'h1234_5678;
        #1;
        total++; if (MemReadData !== 32'h1111_1111) begin bad++; $display("FAIL ram_read_in_write_cycle got=%h exp=11111111", MemReadData); end
        bus_cycle(1'b0, 1'b1, 32'h10, 32'h1234_5678);
        peek(32'h10);
        total++; if (MemReadData !== 32'h1234_5678) begin bad++; $display("FAIL ram_read got=%h exp=12345678", MemReadData); end
        peek(32'h12);
        total++; if (MemReadData !== 32'h1234_5678) begin bad++; $display("FAIL ram_read_unaligned got=%h exp=12345678", MemReadData); end
        bus_cycle(1'b0, 1'b1, 32'h0, 32'hCAFE_0000);
        bus_cycle(1'b0, 1'b1, 32'(RAM_WORDS * 4 - 4), 32'h0BAD_F00D);
        bus_cycle(1'b0, 1'b1, 32'(RAM_WORDS * 4), 32'hDEAD_BEEF);
        peek(32'h0);
        total++; if (MemReadData !== 32'hCAFE_0000) begin bad++; $display("FAIL ram_no_alias got=%h exp=cafe0000", MemReadData); end
        peek(32'(RAM_WORDS * 4 - 4));
        total++; if (MemReadData !== 32'h0BAD_F00D) begin bad++; $display("FAIL ram_last_word got=%h exp=0badf00d", MemReadData); end
        peek(32'(RAM_WORDS * 4));
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL ram_past_end got=%h exp=0", MemReadData); end
    endtask

    task automatic test_timer_overflow();
        bus_cycle(1'b0, 1'b1, ADDR_TH, 32'hFFFF_FFFD);
        bus_cycle(1'b0, 1'b1, ADDR_TL, 32'hFFFF_FFFE);
        bus_cycle(1'b0, 1'b1, ADDR_TCON, 32'h3);
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'hFFFF_FFFE) begin bad++; $display("FAIL tmr_edge_n got=%h exp=fffffffe", MemReadData); end
        bus_cycle(1'b0, 1'b0, ADDR_TL, 32'h0);
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmr_edge_n1 got=%h exp=ffffffff", MemReadData); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL tmr_irq_n1 got=%b exp=0", irq); end
        bus_cycle(1'b0, 1'b0, ADDR_TL, 32'h0);
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'hFFFF_FFFD) begin bad++; $display("FAIL tmr_reload got=%h exp=fffffffd", MemReadData); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL tmr_irq_set got=%b exp=1", irq); end
        peek(ADDR_TCON);
        total++; if (MemReadData !== 32'h7) begin bad++; $display("FAIL tmr_tcon_status got=%h exp=7", MemReadData); end
        bus_cycle(1'b0, 1'b1, ADDR_TCON, 32'h3);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL tmr_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_collision();
        bus_cycle(1'b0, 1'b1, ADDR_TCON, 32'h0);
        bus_cycle(1'b0, 1'b1, ADDR_TL, 32'hFFFF_FFFF);
        bus_cycle(1'b0, 1'b1, ADDR_TCON, 32'h3);
        bus_cycle(1'b0, 1'b1, ADDR_TL, 32'h5);
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'h5) begin bad++; $display("FAIL coll_tl_write_wins got=%h exp=5", MemReadData); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_tl_irq got=%b exp=0", irq); end
        peek(ADDR_TCON);
        total++; if (MemReadData !== 32'h3) begin bad++; $display("FAIL coll_tl_tcon got=%h exp=3", MemReadData); end
        bus_cycle(1'b0, 1'b0, ADDR_TL, 32'h0);
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'h6) begin bad++; $display("FAIL coll_tick_resumes got=%h exp=6", MemReadData); end
        bus_cycle(1'b0, 1'b1, ADDR_TL, 32'hFFFF_FFFF);
        bus_cycle(1'b0, 1'b1, ADDR_TCON, 32'h3);
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'hFFFF_FFFF) begin bad++; $display("FAIL coll_tcon_tl_kept got=%h exp=ffffffff", MemReadData); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_tcon_irq got=%b exp=0", irq); end
    endtask

    task automatic test_periph();
        logic [31:0] exp_th;
        bus_cycle(1'b0, 1'b1, ADDR_LED, 32'hA5);
        bus_cycle(1'b0, 1'b1, ADDR_DIGI, 32'h0F3F);
        total++; if (led !== 8'hA5)   begin bad++; $display("FAIL led_out got=%h exp=a5", led); end
        total++; if (digi !== 12'hF3F) begin bad++; $display("FAIL digi_out got=%h exp=f3f", digi); end
        peek(ADDR_LED);
        total++; if (MemReadData !== 32'hA5) begin bad++; $display("FAIL led_read got=%h exp=a5", MemReadData); end
        peek(ADDR_DIGI);
        total++; if (MemReadData !== 32'hF3F) begin bad++; $display("FAIL digi_read got=%h exp=f3f", MemReadData); end
        peek(32'h4000_0020);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", MemReadData); end
        exp_th = 32'hFFFF_FFFD;
        bus_cycle(1'b0, 1'b1, 32'h4000_0020, 32'hFFFF_FFFF);
        total++; if (led !== 8'hA5 || digi !== 12'hF3F) begin bad++; $display("FAIL unmapped_write_io got=%h/%h exp=a5/f3f", led, digi); end
        peek(ADDR_TH);
        total++; if (MemReadData !== exp_th) begin bad++; $display("FAIL unmapped_write_th got=%h exp=%h", MemReadData, exp_th); end
    endtask

    task automatic test_reset_mid();
        bus_cycle(1'b0, 1'b1, ADDR_LED, 32'h5A);
        bus_cycle(1'b0, 1'b1, ADDR_TL, 32'h10);
        reset = 1'b1; MemWrite = 1'b0; MemAddress = ADDR_TL;
        #2;
        total++; if (led !== 8'h5A || MemReadData !== 32'h10) begin bad++; $display("FAIL reset_no_edge got=%h/%h exp=5a/10", led, MemReadData); end
        bus_cycle(1'b1, 1'b0, ADDR_TL, 32'h0);
        peek(ADDR_TL);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL reset_mid_tl got=%h exp=0", MemReadData); end
        peek(ADDR_TCON);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL reset_mid_tcon got=%h exp=0", MemReadData); end
        peek(ADDR_SYSTICK);
        total++; if (MemReadData !== 32'h0) begin bad++; $display("FAIL reset_mid_systick got=%h exp=0", MemReadData); end
        total++; if (irq !== 1'b0 || led !== 8'h0 || digi !== 12'h0) begin bad++; $display("FAIL reset_mid_io got=%b/%h/%h exp=0/00/000", irq, led, digi); end
    endtask

    task automatic test_systick();
        logic [31:0] s0, s1;
        peek(ADDR_SYSTICK);
        s0 = MemReadData;
        for (int i = 0; i < 100; i++) bus_cycle(1'b0, 1'b0, ADDR_SYSTICK, 32'h0);
        peek(ADDR_SYSTICK);
        s1 = MemReadData;
`ifdef DBUS_SYSTICK_EN
        total++; if (s1 - s0 !== 32'd100) begin bad++; $display("FAIL systick_delta got=%0d exp=100", s1 - s0); end
`else
        total++; if (s0 !== 32'h0 || s1 !== 32'h0) begin bad++; $display("FAIL systick_absent got=%h/%h exp=0/0", s0, s1); end
`endif
        total++; if (s1 !== model_read(ADDR_SYSTICK)) begin bad++; $display("FAIL systick_value got=%h exp=%h", s1, model_read(ADDR_SYSTICK)); end
    endtask

    task automatic test_random();
        logic [31:0] pool [12];
        logic [31:0] addr, data, exp;
        logic        we, rst;
        pool = '{ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_DIGI, ADDR_SYSTICK,
                 32'h4000_0018, 32'h4000_0022, 32'h8000_0010, 32'h0000_0004, 32'h0000_0106, 32'h0000_07FC};
        for (int i = 0; i < 800; i++) begin
            addr = pool[$urandom_range(0, 11)];
            we   = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            data = $urandom;
            if (addr == ADDR_TL && $urandom_range(0, 1) == 1) data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (addr == ADDR_TCON && $urandom_range(0, 2) != 0) data = 32'h3;
            reset = rst; MemWrite = we; MemAddress = addr; MemWriteData = data;
            #1;
            if (model_known(addr)) begin
                exp = model_read(addr);
                total++; if (MemReadData !== exp) begin bad++; $display("FAIL rand_read i=%0d addr=%h got=%h exp=%h", i, addr, MemReadData, exp); end
            end
            bus_cycle(rst, we, addr, data);
            total++;
            if (led !== m_led || digi !== m_digi || irq !== m_tcon[2]) begin
                bad++;
                $display("FAIL rand_outputs i=%0d got=%h/%h/%b exp=%h/%h/%b", i, led, digi, irq, m_led, m_digi, m_tcon[2]);
            end
        end
    endtask

    initial begin
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_systick = 0; m_presc = 0;
        test_reset();
        test_ram();
        test_timer_overflow();
        test_collision();
        test_periph();
        test_reset_mid();
        test_systick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
Memory-side responder for the pipelined CPU's data port. It serves the CPU's MemWrite/MemAddress/MemWriteData outputs and returns MemReadData in the same cycle. It decodes each address to one of three targets: on-chip data RAM, a memory-mapped timer (TH/TL/TCON) that raises an interrupt, or LED/7-segment output registers. It sits between the CPU top and the board I/O.

Parameters:
RAM_WORDS, 512, number of 32-bit data RAM words (power of two).
TIMER_PRESCALE, 1, clock cycles per timer tick (>=1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
MemWrite  in  1  write strobe from the CPU MEM stage
MemAddress  in  32  byte address from the CPU; bits [1:0] are ignored
MemWriteData  in  32  store data
MemReadData  out  32  read data, combinational from MemAddress
led  out  8  LED register
digi  out  12  7-segment register {anode[3:0], segments[7:0]}
irq  out  1  timer interrupt request

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset; it is sampled only at the posedge of clk.
- Reset values:
  - TH = 0, TL = 0, TCON = 0.
  - led = 0, digi = 0, irq = 0.
  - systick = 0, prescale counter = 0.
  - RAM contents are not reset.
- Address map (word-aligned):
  - RAM: 0x0000_0000 .. RAM_WORDS*4-1. Index = MemAddress[log2(RAM_WORDS)+1:2]; the upper address bits must be zero to hit.
  - 0x4000_0000: TH, R/W.
  - 0x4000_0004: TL, R/W.
  - 0x4000_0008: TCON[2:0], R/W. Bit 0 = enable, bit 1 = interrupt enable, bit 2 = status. Reads are zero-extended.
  - 0x4000_000C: led[7:0], R/W.
  - 0x4000_0010: digi[11:0], R/W.
  - 0x4000_0014: systick, read-only.
  - Unmapped addresses: read 0; writes are ignored.
- Reads:
  - Purely combinational, with zero latency; the CPU latches the result into MEM/WB at the same edge.
  - A read never has side effects.
- Writes:
  - Take effect at the posedge on which MemWrite=1; the new value is visible to reads in the following cycle.
  - A read of the same address in the write cycle returns the old value.
- Timer:
  - A tick occurs when TCON[0]=1 and the prescale counter reaches TIMER_PRESCALE-1. The counter then wraps to 0.
  - The prescale counter holds at 0 while TCON[0]=0.
  - On a tick: if TL != 0xFFFF_FFFF, TL <= TL+1. Otherwise TL <= TH, and if TCON[1]=1 then TCON[2] <= 1.
  - irq = TCON[2], registered (no combinational path from the bus).
  - Software clears the status by writing TCON with bit 2 = 0. The written value of bit 2 is loaded verbatim.
- Simultaneous events: a bus write to TL or TCON on the same edge as a tick wins completely. The tick's TL update and status set are both discarded for that edge.
- systick: free-running 32-bit counter, +1 per clk, wraps 0xFFFF_FFFF -> 0.
- Reset during a write or a tick: reset has priority and all registers take their reset values.

Optional Feature:
DBUS_SYSTICK_EN.
- Defined: systick is implemented as above.
- Undefined: no systick counter is built, and 0x4000_0014 reads 0.

Decomposition:
- Package dbus_pkg holds:
  - Address constants: ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_DIGI, ADDR_SYSTICK, PERIPH_BASE.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_ST=2.
- Sub-module dbus_timer owns TH/TL/TCON, the prescaler and irq. It takes the decoded write enables and write data, and returns the register values for the read mux.
- RAM, decode, LED/digi registers, systick and the read mux stay in data_bus_responder.

Test Plan:
- RAM write/read: write 0x1234_5678 to 0x0000_0010, then read 0x0000_0010 -> 0x1234_5678. Read 0x0000_0012 -> same word. The read in the write cycle returns the prior value.
- Timer overflow (TIMER_PRESCALE=1):
  - Setup: write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, then TCON=3 at edge N.
  - Edge N+1: TL=0xFFFF_FFFF.
  - Edge N+2: TL=0xFFFF_FFFD and irq=1; TCON reads 7.
  - Then write TCON=3 -> irq=0 the next cycle.
- Write/tick collision: with TL=0xFFFF_FFFF and TCON=3, write TL=5 on the overflow edge -> TL=5 and irq stays 0.
- Peripherals:
  - Write led=0xA5 and digi=0x0F3F -> outputs 0xA5 and 0xF3F; reading them back returns the same values.
  - Read 0x4000_0020 -> 0. Write 0x4000_0020 -> no register changes.
- Reset: assert reset for 1 cycle mid-count with TCON=3 and TL=0x10 -> at the next edge TL=0, TCON=0, irq=0, led=0, systick=0. Also check that asserting reset without a clock edge changes nothing.
- Systick (DBUS_SYSTICK_EN defined): read 0x4000_0014 at two points 100 cycles apart -> difference is 100. With the macro undefined, the read returns 0.
